// File: rtl/two_digit_sseg_scan.sv
// two_digit_sseg_scan: tear-free two-digit BCD scan onto a common-anode active-low seven-segment display
//   clk, rst_n      : clock, asynchronous active-low reset
//   ones, tens      : BCD digits, sampled only at frame boundaries
//   blank_lz        : live leading-zero blanking of the tens digit
//   seg, an, dp     : active-low segments {g,f,e,d,c,b,a}, anodes, decimal point
//   frame_tick      : one-cycle pulse in the cycle after new digits are latched
//   SSEG_BLINK_EN   : optional blink input plus 8-bit frame counter
module two_digit_sseg_scan #(
    parameter int REFRESH_DIV = 100000,
    parameter int BLANK_CYC   = 2000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] ones,
    input  logic [3:0] tens,
    input  logic       blank_lz,
`ifdef SSEG_BLINK_EN
    input  logic       blink,
`endif
    output logic [6:0] seg,
    output logic [3:0] an,
    output logic       dp,
    output logic       frame_tick
);
    localparam int CW = REFRESH_DIV > 1 ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] BLK  = CW'(BLANK_CYC);
    typedef enum logic {DIG0, DIG1} dsel_t;
    logic [CW-1:0] cnt;
    dsel_t         dsel;
    logic [3:0]    lat_ones, lat_tens, digit;
    logic          wrap, off;
    logic [6:0]    dec;
`ifdef SSEG_BLINK_EN
    logic [7:0]    fcnt;
`endif
    assign wrap = cnt == LAST;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            dsel       <= DIG0;
            lat_ones   <= '0;
            lat_tens   <= '0;
            frame_tick <= 1'b0;
`ifdef SSEG_BLINK_EN
            fcnt       <= '0;
`endif
        end else begin
            cnt        <= wrap ? '0 : cnt + 1'b1;
            frame_tick <= wrap && dsel == DIG1;
            if (wrap)
                dsel <= dsel == DIG0 ? DIG1 : DIG0;
            if (wrap && dsel == DIG1) begin
                lat_ones <= ones;
                lat_tens <= tens;
            end
`ifdef SSEG_BLINK_EN
            fcnt       <= fcnt + {7'd0, frame_tick};
`endif
        end
    end
    assign digit = dsel == DIG1 ? lat_tens : lat_ones;
    // rst_n forces the display dark in the same instant reset is asserted
`ifdef SSEG_BLINK_EN
    assign off = !rst_n || cnt < BLK || (dsel == DIG1 && blank_lz && lat_tens == 4'd0) || (blink && fcnt[7]);
`else
    assign off = !rst_n || cnt < BLK || (dsel == DIG1 && blank_lz && lat_tens == 4'd0);
`endif
    always_comb begin
        dec = 7'b0111111;
        case (digit)
            4'd0: dec = 7'b1000000;
            4'd1: dec = 7'b1111001;
            4'd2: dec = 7'b0100100;
            4'd3: dec = 7'b0110000;
            4'd4: dec = 7'b0011001;
            4'd5: dec = 7'b0010010;
            4'd6: dec = 7'b0000010;
            4'd7: dec = 7'b1111000;
            4'd8: dec = 7'b0000000;
            4'd9: dec = 7'b0010000;
            default: dec = 7'b0111111;
        endcase
    end
    assign an  = off ? 4'b1111 : (dsel == DIG1 ? 4'b1101 : 4'b1110);
    assign seg = off ? 7'b1111111 : dec;
    assign dp  = 1'b1;
endmodule

// File: tb/tb_two_digit_sseg_scan.sv
// tb_two_digit_sseg_scan: directed self-checking bench for two_digit_sseg_scan (REFRESH_DIV=8, BLANK_CYC=2)
module tb_two_digit_sseg_scan;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] ones = 4'd5;
    logic [3:0] tens = 4'd1;
    logic       blank_lz = 1'b0;
    logic [6:0] seg;
    logic [3:0] an;
    logic       dp;
    logic       frame_tick;
    int vectors = 0;
    int miscompares = 0;

    localparam logic [11:0] OFF = {4'b1111, 7'b1111111, 1'b1};

    always #5 clk = ~clk;

    two_digit_sseg_scan #(.REFRESH_DIV(8), .BLANK_CYC(2)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .ones(ones),
        .tens(tens),
        .blank_lz(blank_lz),
`ifdef SSEG_BLINK_EN
        .blink(1'b0),
`endif
        .seg(seg),
        .an(an),
        .dp(dp),
        .frame_tick(frame_tick)
    );

    function automatic logic [11:0] lit(input logic [3:0] a, input logic [6:0] s);
        return {a, s, 1'b1};
    endfunction

    task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic disp(input string tag, input logic [11:0] exp);
        chk(tag, {an, seg, dp}, exp);
    endtask

    task automatic adv(input int n);
        repeat (n) @(negedge clk);
    endtask

    // waits (bounded) for frame_tick and checks how many cycles it took
    task automatic tick(input string tag, input int exp_n);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (frame_tick !== 1'b1 && n < 40);
        chk({tag, "_wait"}, 12'(n), 12'(exp_n));
        chk({tag, "_ft"}, {11'd0, frame_tick}, 12'd1);
    endtask

    initial begin
        adv(2);
        disp("reset_out", OFF);
        chk("reset_ft", {11'd0, frame_tick}, 12'd0);
        rst_n = 1'b1;
        #1 disp("cyc0_blank", OFF);
        adv(1);
        disp("cyc1_blank", OFF);
        adv(1);
        disp("cyc2_zero", lit(4'b1110, 7'b1000000));
        adv(8);
        disp("dig1_zero", lit(4'b1101, 7'b1000000));
        tick("tick1", 6);
        disp("tick1_blank", OFF);
        adv(1);
        chk("ft_one_cycle", {11'd0, frame_tick}, 12'd0);
        adv(1);
        disp("ones5", lit(4'b1110, 7'b0010010));
        adv(1);
        ones = 4'd9;
        adv(2);
        disp("ones5_hold", lit(4'b1110, 7'b0010010));
        adv(5);
        disp("tens1", lit(4'b1101, 7'b1111001));
        tick("tick2", 6);
        adv(2);
        disp("ones9", lit(4'b1110, 7'b0010000));
        tens = 4'd0;
        ones = 4'd7;
        blank_lz = 1'b1;
        tick("tick3", 14);
        adv(2);
        disp("ones7", lit(4'b1110, 7'b1111000));
        adv(5);
        for (int k = 8; k < 16; k++) begin
            adv(1);
            disp($sformatf("lz_blank_%0d", k - 8), OFF);
        end
        blank_lz = 1'b0;
        tick("tick4", 1);
        adv(10);
        disp("lz_off_zero", lit(4'b1101, 7'b1000000));
        ones = 4'hC;
        tens = 4'd3;
        tick("tick5", 6);
        adv(2);
        disp("ones_dash", lit(4'b1110, 7'b0111111));
        adv(11);
        disp("tens3", lit(4'b1101, 7'b0110000));
        #1 rst_n = 1'b0;
        #1 disp("midscan_reset", OFF);
        chk("midscan_ft", {11'd0, frame_tick}, 12'd0);
        rst_n = 1'b1;
        #1 disp("post_rst_cyc0", OFF);
        adv(1);
        disp("post_rst_cyc1", OFF);
        adv(1);
        disp("post_rst_dig0", lit(4'b1110, 7'b1000000));
        adv(8);
        disp("post_rst_dig1", lit(4'b1101, 7'b1000000));
        tick("tick6", 6);
        adv(2);
        disp("post_rst_dash", lit(4'b1110, 7'b0111111));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
